upd7800: RTL and testbench
==========================

UPD7800 -- requirements
Module: upd7800

Interface
REQ-001 CLK  in  1  system clock; all state changes on its rising edge.
REQ-002 RESETB  in  1  reset, synchronous, active-low.
REQ-003 CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE  in  1 each  one-CLK phase strobes, repeating in that order; 4 CLK = one state.
REQ-004 INT0, INT1, INT2  in  1 each  interrupt requests; two-flop synchronized, otherwise unused in this revision.
REQ-005 A  out  16  address bus.
REQ-006 DB_I  in  8  read data.
REQ-007 DB_O  out  8  write data.
REQ-008 DB_OE  out  1  high while DB_O is driven.
REQ-009 M1  out  1  high during opcode-fetch cycles.
REQ-010 RDB, WRB  out  1 each  read and write strobes, active-low.
REQ-011 PA_O  out  8  port A output.
REQ-012 PB_I  in  8  port B input.
REQ-013 PB_O, PB_OE  out  8 each  port B output and enable.
REQ-014 PC_I  in  8  port C input.
REQ-015 PC_O, PC_OE  out  8 each  port C output and enable.

Function
REQ-016 Internal state shall be named pc, sp, ir, v, a, b, c, d, e, h, l and skip; the bench probes and forces b, c, e, l, pc and ir.
REQ-017 State advance:
- Machine state advances only on CP1_POSEDGE.
- A memory cycle is three states: T1 drives A, T2 and T3 assert the strobe, and DB_I is captured at the T3 CP2_POSEDGE.
- Memory has synchronous read with 1-CLK latency.
REQ-018 Write cycle: DB_O and DB_OE are valid T1-T3, and WRB is low T2-T3 (covering one CLK falling edge).
REQ-019 Opcode fetch: a memory read with M1=1; ir is loaded at fetch end and pc is incremented.
REQ-020 Opcodes, with 16-bit register pairs BC, DE and HL:
- 00 NOP.
- 68-6F MVI {V,A,B,C,D,E,H,L},imm8.
- 04/14/24/34 LXI {SP,BC,DE,HL},imm16, little-endian.
- 41/42/43 INR A/B/C; 51/52/53 DCR A/B/C.
- 2D LDAX (HL) -> A; 3D STAX A -> (HL).
- 54 JMP imm16; 44 CALL imm16; B8 RET.
- C0-FF JR: target = address of the JR + 1 + sign-extended 6-bit displacement.
REQ-021 FF is JR to its own address and shall loop forever with ir=FF.
REQ-022 INR/DCR arithmetic is 8-bit modulo 256; skip is set when the result wraps (FF->00 for INR, 00->FF for DCR), otherwise skip is cleared.
REQ-023 When skip is set, the next instruction is fetched in full (operands included) but not executed, and skip is then cleared.
REQ-024 CALL pushes the return address: high byte to SP-1, low byte to SP-2, then SP-=2; RET pops in reverse order.
REQ-025 Undefined opcodes execute as NOP.
REQ-026 Ports are constant in this revision: PA_O=00, PB_O=00, PB_OE=00, PC_O=00, PC_OE=00.

Reset
REQ-027 While RESETB=0 at a CLK rising edge:
- pc=0000, sp=0000, ir=00, all registers 00, skip=0.
- RDB=1, WRB=1, DB_OE=0, M1=0, A=0000.
REQ-028 The first opcode fetch from 0000 begins at the first CP1_POSEDGE after RESETB returns high.
REQ-029 Reset asserted mid-cycle aborts the cycle immediately, with no partial write.

Structure
REQ-030 Shared package upd7800_pkg shall hold the opcode constants, the machine-state enum (FETCH, OPER1, OPER2, MEMRD, MEMWR, PUSH, POP) and the bus-phase enum (T1, T2, T3).
REQ-031 One sub-module, upd7800_bus, shall sequence T1-T3 and generate A, RDB, WRB, DB_OE and M1; decode and execute live in upd7800.

Verification
REQ-032 Release reset -> first cycle has A=0000, M1=1, RDB low for T2-T3 only, and WRB stays high.
REQ-033 Program 6B 03 53 FE FF (MVI C,3; DCR C; JR -2; JR $) -> DCR runs 4 times, c ends at FF, and execution parks at 0004 with ir=FF.
REQ-034 Program 34 81 FF 69 5A 3D -> one write to FF81 with DB_O=5A and WRB low for exactly 2 states.
REQ-035 Program 04 00 00 44 10 00 at 0000 and B8 at 0010 -> pushes 00 to FFFF and 06 to FFFE, returns to 0006, and sp ends at 0000.
REQ-036 Assert RESETB low during the T2 of a STAX write -> no memory write occurs, and the next fetch is at 0000.

Source files
------------

// File: rtl/upd7800_pkg.sv
// Shared opcode constants, machine/bus state encodings and decode helpers
// for the uPD7800-subset core.
package upd7800_pkg;

  typedef enum logic [2:0] {FETCH, OPER1, OPER2, MEMRD, MEMWR, PUSH, POP} mstate_t;
  typedef enum logic [1:0] {T1, T2, T3} bphase_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LXI_SP = 8'h04;
  localparam logic [7:0] OP_LXI_BC = 8'h14;
  localparam logic [7:0] OP_LXI_DE = 8'h24;
  localparam logic [7:0] OP_LXI_HL = 8'h34;
  localparam logic [7:0] OP_INR_A  = 8'h41;
  localparam logic [7:0] OP_INR_B  = 8'h42;
  localparam logic [7:0] OP_INR_C  = 8'h43;
  localparam logic [7:0] OP_DCR_A  = 8'h51;
  localparam logic [7:0] OP_DCR_B  = 8'h52;
  localparam logic [7:0] OP_DCR_C  = 8'h53;
  localparam logic [7:0] OP_LDAX   = 8'h2D;
  localparam logic [7:0] OP_STAX   = 8'h3D;
  localparam logic [7:0] OP_JMP    = 8'h54;
  localparam logic [7:0] OP_CALL   = 8'h44;
  localparam logic [7:0] OP_RET    = 8'hB8;

  function automatic logic is_mvi(input logic [7:0] op);
    return op[7:3] == 5'b01101;
  endfunction

  function automatic logic [1:0] operand_count(input logic [7:0] op);
    if (is_mvi(op)) return 2'd1;
    case (op)
      OP_LXI_SP, OP_LXI_BC, OP_LXI_DE, OP_LXI_HL, OP_JMP, OP_CALL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_incdec(input logic [7:0] op);
    case (op)
      OP_INR_A, OP_INR_B, OP_INR_C, OP_DCR_A, OP_DCR_B, OP_DCR_C: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/upd7800_bus.sv
// Three-state memory cycle sequencer: latches the core's request at T1,
// drives the strobe through T2-T3 and flags completion at T3 CP2 rise.
module upd7800_bus
  import upd7800_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        cp1_posedge,
  input  logic        cp2_posedge,
  input  logic [15:0] req_addr,
  input  logic        req_wr,
  input  logic        req_m1,
  input  logic [7:0]  req_data,
  output logic [15:0] addr,
  output logic [7:0]  db_o,
  output logic        db_oe,
  output logic        m1,
  output logic        rdb,
  output logic        wrb,
  output logic        done
);

  bphase_t phase_reg;
  logic    active_reg;
  logic    wr_reg;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      phase_reg  <= T1;
      active_reg <= 1'b0;
      wr_reg     <= 1'b0;
      addr       <= 16'h0000;
      db_o       <= 8'h00;
      db_oe      <= 1'b0;
      m1         <= 1'b0;
      rdb        <= 1'b1;
      wrb        <= 1'b1;
    end else if (cp1_posedge) begin
      if (!active_reg || phase_reg == T3) begin
        phase_reg  <= T1;
        active_reg <= 1'b1;
        wr_reg     <= req_wr;
        addr       <= req_addr;
        db_o       <= req_data;
        db_oe      <= req_wr;
        m1         <= req_m1;
        rdb        <= 1'b1;
        wrb        <= 1'b1;
      end else begin
        phase_reg <= (phase_reg == T1) ? T2 : T3;
        rdb       <= wr_reg;
        wrb       <= ~wr_reg;
      end
    end
  end

  assign done = active_reg && (phase_reg == T3) && cp2_posedge;

endmodule

// File: rtl/upd7800.sv
// uPD7800-subset CPU: decode/execute state machine on top of the bus
// sequencer; every machine state is exactly one memory cycle.
module upd7800
  import upd7800_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        CP1_POSEDGE,
  input  logic        CP1_NEGEDGE,
  input  logic        CP2_POSEDGE,
  input  logic        CP2_NEGEDGE,
  input  logic        INT0,
  input  logic        INT1,
  input  logic        INT2,
  output logic [15:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  output logic        M1,
  output logic        RDB,
  output logic        WRB,
  output logic [7:0]  PA_O,
  input  logic [7:0]  PB_I,
  output logic [7:0]  PB_O,
  output logic [7:0]  PB_OE,
  input  logic [7:0]  PC_I,
  output logic [7:0]  PC_O,
  output logic [7:0]  PC_OE
);

  logic [15:0] pc, sp;
  logic [7:0]  ir, v, a, b, c, d, e, h, l;
  logic        skip;
  mstate_t     state_reg;
  logic        step_reg;
  logic [7:0]  tmp_lo_reg;
  logic [15:0] target_reg;

  logic [15:0] req_addr;
  logic        req_wr, req_m1, bus_done;
  logic [7:0]  req_data;
  logic [7:0]  alu_src, alu_res;
  logic        alu_wrap;
  logic [15:0] jr_target;
  logic        unused_sink;

  wire [2:0] int_req = {INT2, INT1, INT0};
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_int_sync
      logic meta_reg, sync_unused_reg;
      always_ff @(posedge CLK) begin
        if (!RESETB) begin
          meta_reg        <= 1'b0;
          sync_unused_reg <= 1'b0;
        end else begin
          meta_reg        <= int_req[gi];
          sync_unused_reg <= meta_reg;
        end
      end
    end
  endgenerate

  assign unused_sink = ^{CP1_NEGEDGE, CP2_NEGEDGE, PB_I, PC_I, v, d, e};

  assign PA_O  = 8'h00;
  assign PB_O  = 8'h00;
  assign PB_OE = 8'h00;
  assign PC_O  = 8'h00;
  assign PC_OE = 8'h00;

  always_comb begin
    req_addr = pc;
    req_wr   = 1'b0;
    req_m1   = 1'b0;
    req_data = 8'h00;
    case (state_reg)
      FETCH: req_m1 = 1'b1;
      MEMRD: req_addr = {h, l};
      MEMWR: begin
        req_addr = {h, l};
        req_wr   = 1'b1;
        req_data = a;
      end
      PUSH: begin
        req_wr   = 1'b1;
        req_addr = step_reg ? sp - 16'd2 : sp - 16'd1;
        req_data = step_reg ? pc[7:0] : pc[15:8];
      end
      POP: req_addr = step_reg ? sp + 16'd1 : sp;
      default: ;
    endcase
  end

  // INR/DCR operate straight off the opcode byte as it arrives on DB_I.
  always_comb begin
    case (DB_I[1:0])
      2'd2:    alu_src = b;
      2'd3:    alu_src = c;
      default: alu_src = a;
    endcase
    alu_res   = DB_I[4] ? alu_src - 8'd1 : alu_src + 8'd1;
    alu_wrap  = DB_I[4] ? (alu_src == 8'h00) : (alu_src == 8'hFF);
    jr_target = pc + 16'd1 + {{10{DB_I[5]}}, DB_I[5:0]};
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      pc <= 16'h0000; sp <= 16'h0000; ir <= 8'h00;
      v <= 8'h00; a <= 8'h00; b <= 8'h00; c <= 8'h00;
      d <= 8'h00; e <= 8'h00; h <= 8'h00; l <= 8'h00;
      skip       <= 1'b0;
      state_reg  <= FETCH;
      step_reg   <= 1'b0;
      tmp_lo_reg <= 8'h00;
      target_reg <= 16'h0000;
    end else if (bus_done) begin
      case (state_reg)
        FETCH: begin
          ir <= DB_I;
          pc <= pc + 16'd1;
          if (operand_count(DB_I) != 2'd0) state_reg <= OPER1;
          else if (skip) skip <= 1'b0;
          else if (DB_I[7:6] == 2'b11) pc <= jr_target;
          else if (is_incdec(DB_I)) begin
            skip <= alu_wrap;
            case (DB_I[1:0])
              2'd2:    b <= alu_res;
              2'd3:    c <= alu_res;
              default: a <= alu_res;
            endcase
          end else begin
            case (DB_I)
              OP_LDAX: state_reg <= MEMRD;
              OP_STAX: state_reg <= MEMWR;
              OP_RET: begin state_reg <= POP; step_reg <= 1'b0; end
              default: ;
            endcase
          end
        end
        OPER1: begin
          pc         <= pc + 16'd1;
          tmp_lo_reg <= DB_I;
          if (is_mvi(ir)) begin
            state_reg <= FETCH;
            skip      <= 1'b0;
            if (!skip) begin
              case (ir[2:0])
                3'd0: v <= DB_I;  3'd1: a <= DB_I;
                3'd2: b <= DB_I;  3'd3: c <= DB_I;
                3'd4: d <= DB_I;  3'd5: e <= DB_I;
                3'd6: h <= DB_I;  default: l <= DB_I;
              endcase
            end
          end else state_reg <= OPER2;
        end
        OPER2: begin
          pc        <= pc + 16'd1;
          state_reg <= FETCH;
          skip      <= 1'b0;
          if (!skip) begin
            case (ir)
              OP_LXI_SP: sp <= {DB_I, tmp_lo_reg};
              OP_LXI_BC: begin b <= DB_I; c <= tmp_lo_reg; end
              OP_LXI_DE: begin d <= DB_I; e <= tmp_lo_reg; end
              OP_LXI_HL: begin h <= DB_I; l <= tmp_lo_reg; end
              OP_JMP:    pc <= {DB_I, tmp_lo_reg};
              OP_CALL: begin
                target_reg <= {DB_I, tmp_lo_reg};
                state_reg  <= PUSH;
                step_reg   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MEMRD: begin a <= DB_I; state_reg <= FETCH; end
        MEMWR: state_reg <= FETCH;
        PUSH: begin
          if (!step_reg) step_reg <= 1'b1;
          else begin
            pc <= target_reg; sp <= sp - 16'd2;
            step_reg <= 1'b0; state_reg <= FETCH;
          end
        end
        POP: begin
          if (!step_reg) begin tmp_lo_reg <= DB_I; step_reg <= 1'b1; end
          else begin
            pc <= {DB_I, tmp_lo_reg}; sp <= sp + 16'd2;
            step_reg <= 1'b0; state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  upd7800_bus u_bus (
    .clk         (CLK),
    .resetb      (RESETB),
    .cp1_posedge (CP1_POSEDGE),
    .cp2_posedge (CP2_POSEDGE),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_m1      (req_m1),
    .req_data    (req_data),
    .addr        (A),
    .db_o        (DB_O),
    .db_oe       (DB_OE),
    .m1          (M1),
    .rdb         (RDB),
    .wrb         (WRB),
    .done        (bus_done)
  );

endmodule

// File: tb/tb_upd7800.sv
// Directed bench for upd7800: phase generator, synchronous-read memory and
// short programs with hand-computed outcomes.
module tb_upd7800;

  logic        CLK = 1'b0, RESETB = 1'b0;
  logic        CP1_POSEDGE = 1'b0, CP1_NEGEDGE = 1'b0, CP2_POSEDGE = 1'b0, CP2_NEGEDGE = 1'b0;
  logic        INT0 = 1'b0, INT1 = 1'b0, INT2 = 1'b0;
  logic [15:0] A;
  logic [7:0]  DB_I, DB_O, PA_O, PB_O, PB_OE, PC_O, PC_OE;
  logic [7:0]  PB_I = 8'h00, PC_I = 8'h00;
  logic        DB_OE, M1, RDB, WRB;

  logic [7:0]  mem [0:65535];
  int          vectors = 0, miscompares = 0;
  int          wr_count = 0, fetch_count = 0, dcr_fetches = 0, wrb_low_run = 0, wrb_low_clks = 0;
  logic [15:0] last_fetch_addr = 16'h0, last_wr_addr = 16'h0, wr_addr_l = 16'h0;
  logic [7:0]  last_wr_data = 8'h0, wr_data_l = 8'h0;
  logic        wrb_prev = 1'b1, rdb_prev = 1'b1;
  bit          ok;
  int          n, wlow;

  upd7800 dut (
    .CLK(CLK), .RESETB(RESETB),
    .CP1_POSEDGE(CP1_POSEDGE), .CP1_NEGEDGE(CP1_NEGEDGE),
    .CP2_POSEDGE(CP2_POSEDGE), .CP2_NEGEDGE(CP2_NEGEDGE),
    .INT0(INT0), .INT1(INT1), .INT2(INT2),
    .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE), .M1(M1), .RDB(RDB), .WRB(WRB),
    .PA_O(PA_O), .PB_I(PB_I), .PB_O(PB_O), .PB_OE(PB_OE),
    .PC_I(PC_I), .PC_O(PC_O), .PC_OE(PC_OE)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    int ph = 0;
    forever begin
      @(negedge CLK);
      CP1_POSEDGE = (ph == 0); CP1_NEGEDGE = (ph == 1);
      CP2_POSEDGE = (ph == 2); CP2_NEGEDGE = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  always @(posedge CLK) DB_I <= mem[A];

  // Writes commit when WRB rises outside reset, so an aborted cycle leaves memory untouched.
  always @(posedge CLK) begin
    if (WRB === 1'b0) begin
      wr_addr_l = A; wr_data_l = DB_O; wrb_low_run = wrb_low_run + 1;
    end else begin
      if (wrb_prev == 1'b0 && RESETB) begin
        mem[wr_addr_l] = wr_data_l;
        wr_count = wr_count + 1;
        last_wr_addr = wr_addr_l; last_wr_data = wr_data_l; wrb_low_clks = wrb_low_run;
        $display("write addr=%04h data=%02h wrb_low_clks=%0d", wr_addr_l, wr_data_l, wrb_low_run);
      end
      wrb_low_run = 0;
    end
    wrb_prev = WRB;
    if (RDB == 1'b0 && rdb_prev == 1'b1 && M1) begin
      fetch_count = fetch_count + 1;
      last_fetch_addr = A;
      if (A == 16'h0002) dcr_fetches = dcr_fetches + 1;
    end
    rdb_prev = RDB;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_program(input logic [7:0] prog [8]);
    RESETB = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    repeat (4) @(negedge CLK);
    wr_count = 0; fetch_count = 0; dcr_fetches = 0;
  endtask

  task automatic run_until_park(input logic [15:0] addr, output bit found);
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (dut.ir == 8'hFF && dut.pc == addr) begin found = 1; break; end
    end
    repeat (40) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] p1 [8] = '{8'h6B, 8'h03, 8'h53, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] p2 [8] = '{8'h34, 8'h81, 8'hFF, 8'h69, 8'h5A, 8'h3D, 8'hFF, 8'h00};
    logic [7:0] p3 [8] = '{8'h04, 8'h00, 8'h00, 8'h44, 8'h10, 8'h00, 8'hFF, 8'h00};
    logic [7:0] p4 [8] = '{8'h6A, 8'hFF, 8'h42, 8'h69, 8'h11, 8'h43, 8'hFF, 8'h00};

    // Reset state and first opcode fetch
    start_program(p1);
    check("rst_A", A, 16'h0000);
    check("rst_RDB", RDB, 1'b1);
    check("rst_WRB", WRB, 1'b1);
    check("rst_DB_OE", DB_OE, 1'b0);
    check("rst_M1", M1, 1'b0);
    check("rst_pc", dut.pc, 16'h0000);
    check("rst_ir", dut.ir, 8'h00);
    RESETB = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (M1) begin ok = 1; break; end
    end
    check("first_m1_seen", ok, 1'b1);
    check("first_A", A, 16'h0000);
    check("first_t1_RDB", RDB, 1'b1);
    n = 0; wlow = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (!RDB) n++;
      if (!WRB) wlow++;
    end
    check("first_rdb_low_clks", n, 8);
    check("first_wrb_low_clks", wlow, 0);

    // DCR loop with skip over the backward JR
    run_until_park(16'h0004, ok);
    check("p1_parked", ok, 1'b1);
    check("p1_c", dut.c, 8'hFF);
    check("p1_dcr_fetches", dcr_fetches, 4);
    check("p1_ir", dut.ir, 8'hFF);
    check("p1_last_fetch", last_fetch_addr, 16'h0004);

    // STAX write cycle
    start_program(p2);
    RESETB = 1'b1;
    run_until_park(16'h0006, ok);
    check("p2_parked", ok, 1'b1);
    check("p2_l", dut.l, 8'h81);
    check("p2_wr_count", wr_count, 1);
    check("p2_wr_addr", last_wr_addr, 16'hFF81);
    check("p2_wr_data", last_wr_data, 8'h5A);
    check("p2_wrb_low_clks", wrb_low_clks, 8);

    // CALL / RET through the stack
    start_program(p3);
    mem[16'h0010] = 8'hB8; mem[16'hFFFF] = 8'hAA; mem[16'hFFFE] = 8'hAA;
    RESETB = 1'b1;
    run_until_park(16'h0006, ok);
    check("p3_parked", ok, 1'b1);
    check("p3_push_hi", mem[16'hFFFF], 8'h00);
    check("p3_push_lo", mem[16'hFFFE], 8'h06);
    check("p3_wr_count", wr_count, 2);
    check("p3_sp", dut.sp, 16'h0000);

    // INR wrap skips a two-byte MVI, then a plain INR runs
    start_program(p4);
    RESETB = 1'b1;
    run_until_park(16'h0006, ok);
    check("p4_parked", ok, 1'b1);
    check("p4_b", dut.b, 8'h00);
    check("p4_a", dut.a, 8'h00);
    check("p4_c", dut.c, 8'h01);
    check("p4_skip", dut.skip, 1'b0);

    // Reset during T2 of the STAX write
    start_program(p2);
    mem[16'hFF81] = 8'h00;
    RESETB = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (!WRB) begin ok = 1; break; end
    end
    check("p5_wrb_seen", ok, 1'b1);
    @(negedge CLK);
    RESETB = 1'b0;
    repeat (4) @(negedge CLK);
    check("p5_rst_WRB", WRB, 1'b1);
    check("p5_rst_DB_OE", DB_OE, 1'b0);
    check("p5_rst_pc", dut.pc, 16'h0000);
    fetch_count = 0;
    RESETB = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (fetch_count > 0) begin ok = 1; break; end
    end
    check("p5_refetch_seen", ok, 1'b1);
    check("p5_refetch_addr", last_fetch_addr, 16'h0000);
    check("p5_wr_count", wr_count, 0);
    check("p5_mem_untouched", mem[16'hFF81], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
